// File: rtl/miter_monitor.sv
// Equivalence miter monitor: compares two circuit outputs over a programmed run.
// Optional first-mismatch history buffer enabled by defining MITER_HIST_EN.
module miter_monitor #(
    parameter int CNT_W      = 16,
    parameter int HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop_on_fail,
    input  logic [CNT_W-1:0]              n_cycles,
    input  logic [3:0]                    vec,
    input  logic                          f1,
    input  logic                          f2,
    output logic                          busy,
    output logic                          done,
    output logic                          fail,
    output logic [CNT_W-1:0]              cycle_cnt,
    output logic [CNT_W-1:0]              mismatch_cnt,
    output logic [CNT_W-1:0]              first_fail_cycle,
    output logic [3:0]                    first_fail_vec,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [5:0]                    hist_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] n_lat;
    logic             sof_lat;
    logic             mism;
    logic             launch;
    logic             last;

    assign mism   = f1 ^ f2;
    assign launch = (state != RUN) && start;
    assign last   = (cycle_cnt == n_lat - CNT_W'(1)) || (mism && sof_lat);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (n_cycles == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat            <= '0;
            sof_lat          <= 1'b0;
            fail             <= 1'b0;
            cycle_cnt        <= '0;
            mismatch_cnt     <= '0;
            first_fail_cycle <= '0;
            first_fail_vec   <= '0;
        end else if (launch) begin
            n_lat            <= n_cycles;
            sof_lat          <= stop_on_fail;
            fail             <= 1'b0;
            cycle_cnt        <= '0;
            mismatch_cnt     <= '0;
            first_fail_cycle <= '0;
            first_fail_vec   <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (mism) begin
                fail <= 1'b1;
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
                // Only the first divergence of a run is captured
                if (!fail) begin
                    first_fail_cycle <= cycle_cnt;
                    first_fail_vec   <= vec;
                end
            end
        end
    end

`ifdef MITER_HIST_EN
    logic [5:0] hist [HIST_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (launch) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (state == RUN && !fail) begin
            // Freezing on fail leaves the first mismatch at entry 0
            hist[0] <= {vec, f1, f2};
            for (int i = 1; i < HIST_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    assign hist_data = hist[hist_idx];
`else
    logic unused_hist;

    assign unused_hist = ^hist_idx;
    assign hist_data   = '0;
`endif

endmodule

// File: doc/miter_monitor.md
# miter_monitor

Downstream equivalence checker for the combinational/sequential circuit pairs under test. It consumes the `f` outputs of two candidate circuits driven by the same input vector each clock and compares them over a programmed number of cycles. It reports pass/fail, a saturating mismatch count, and the cycle index and input vector of the first divergence. It sits directly after the circuit pair in the equivalence-checking testbench top.

## Interface
Parameters:
- `CNT_W`, 16, width of cycle and mismatch counters
- `HIST_DEPTH`, 8, number of history entries; must be a power of two, ≥2; used only with `MITER_HIST_EN`

Ports:
- `clk`  in  1  rising-edge clock, same clock as the circuits' flip-flops
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run; sampled in IDLE/DONE only
- `stop_on_fail`  in  1  latched at start; end the run on first mismatch
- `n_cycles`  in  CNT_W  number of compare samples; latched at start
- `vec`  in  4  {a,b,c,d} applied to both circuits this cycle
- `f1`, `f2`  in  1 each  outputs of circuit 1 and circuit 2
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `fail`  out  1  sticky: at least one mismatch in the current/last run
- `cycle_cnt`  out  CNT_W  samples compared so far
- `mismatch_cnt`  out  CNT_W  mismatches, saturating at all-ones
- `first_fail_cycle`  out  CNT_W  `cycle_cnt` value at first mismatch
- `first_fail_vec`  out  4  `vec` at first mismatch
- `hist_idx`  in  $clog2(HIST_DEPTH)  history read index; 0 = newest
- `hist_data`  out  6  {vec,f1,f2} history entry, combinational read

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; every output 0.
- IDLE or DONE with `start`=1 at an edge:
  - clear `cycle_cnt`, `mismatch_cnt`, `fail`, `first_fail_*`, and history.
  - latch `n_cycles` and `stop_on_fail`.
  - go to RUN; if `n_cycles`=0, go to DONE instead with `fail`=0.
- RUN, each edge: sample `vec`, `f1`, `f2`.
  - Mismatch means `f1`≠`f2`. On a mismatch, increment `mismatch_cnt` (saturating) and set `fail`.
  - On the first mismatch of the run, capture `first_fail_cycle`=current `cycle_cnt` and `first_fail_vec`=`vec`.
  - Increment `cycle_cnt`.
- RUN exits to DONE after the sample taken with `cycle_cnt`=latched `n_cycles`−1, or after the first mismatch sample when `stop_on_fail` is latched high. The exiting sample is fully counted and captured.
- `start` is ignored in RUN. `n_cycles` and `stop_on_fail` changes during RUN have no effect.
- DONE holds all results stable until the next `start`.
- `rst_n` low mid-run forces IDLE and zeros all state immediately (asynchronous); no partial results are retained.

## Timing
- `busy` rises the edge after `start` is sampled; first compare occurs at the next edge.
- A run of N samples: `busy` high for exactly N cycles; `done` rises on the edge of the N-th sample.
- Counters and capture registers update on the same edge as the sample; visible the following cycle.
- `f1` and `f2` must be settled before the edge. The monitor adds no synchronisation; the inputs are in the `clk` domain.
- Counter arithmetic is unsigned CNT_W; `cycle_cnt` cannot wrap because the run ends at `n_cycles`≤2^CNT_W−1.

## Configuration
- `MITER_HIST_EN` defined:
  - `HIST_DEPTH`-entry shift register of {vec,f1,f2}, written every RUN sample.
  - Writes freeze after the first-mismatch sample, so the mismatch is entry 0.
  - `hist_data` = entry `hist_idx`; unwritten entries read 0.
- Not defined: no history storage; `hist_data` is constant 0; `hist_idx` is ignored. Ports are present in both builds.

## Test plan
- Identical circuits (`f1`=`f2` always), `n_cycles`=10 → `done` after 10 busy cycles; `fail`=0, `mismatch_cnt`=0, `cycle_cnt`=10.
- `f2` inverted on samples 3 and 7, `n_cycles`=10, `stop_on_fail`=0 → `fail`=1, `mismatch_cnt`=2, `first_fail_cycle`=3, `first_fail_vec`=vec at sample 3.
- Same stimulus with `stop_on_fail`=1 → `done` after 4 busy cycles; `cycle_cnt`=4, `mismatch_cnt`=1.
- `n_cycles`=0 → DONE one edge after `start`, `busy` never high. Then CNT_W=4, constant mismatch, `n_cycles`=15 → `mismatch_cnt`=15, saturated.
- `rst_n` pulsed low at sample 5 of a 10-sample run → all outputs 0 immediately; a new `start` runs cleanly from `cycle_cnt`=0.
- `MITER_HIST_EN`, `HIST_DEPTH`=8, first mismatch at sample 5 → `hist_idx`=0 gives the sample 5 entry, `hist_idx`=5 gives the sample 0 entry, `hist_idx`=6 reads 0.
